rtc_key_rotator: RTL and testbench

RTC_KEY_ROTATOR -- requirements
Module: rtc_key_rotator

---
 rtl/rtc_key_rotator.sv | 98 +++++++++
 tb/tb_rtc_key_rotator.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/rtc_key_rotator.sv
// rtc_key_rotator: four-slot key store that rotates the active key on 5 s ticks; optional 7-seg scanner under KEY_ROTATE_SCAN_EN
module rtc_key_rotator #(
   parameter int KEY_W    = 32,
   parameter int NUM_KEYS = 4
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             clk_500Hz,
   input  logic             clk_5s,
   input  logic             rotate_en,
   input  logic             key_load,
   input  logic [1:0]       key_load_idx,
   input  logic [KEY_W-1:0] key_load_data,
   output logic [KEY_W-1:0] key_out,
   output logic [1:0]       key_idx,
   output logic             key_valid,
   output logic [3:0]       seg_an,
   output logic [3:0]       seg_nib
);
   typedef enum logic [1:0] {EMPTY, READY, ROTATE} state_t;
   state_t state, state_n;
   logic [KEY_W-1:0] slot [NUM_KEYS];
   logic [NUM_KEYS-1:0] slot_valid, nv;
   logic [1:0] arm, n1, n2, n3, nxt;
   logic [2:0] s5;
   logic armed, tick5, found, rot, first_load, act_load;
   logic [KEY_W-1:0] nxt_data;
   // Edge detectors stay disarmed until the previous-value flops hold real samples, so a high input at release is not a rise
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) arm <= '0;
      else if (!armed) arm <= arm + 2'd1;
   assign armed = &arm;
   // clk_5s synchronizer: s5[1:0] two-flop sync, s5[2] previous value
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) s5 <= '0;
      else s5 <= {s5[1:0], clk_5s};
   assign tick5 = armed & s5[1] & ~s5[2];
   // Rotation looks at the mask including a same-cycle load, and picks up the load data if it targets the new slot
   always_comb begin
      nv = slot_valid | (key_load ? NUM_KEYS'(1) << key_load_idx : '0);
      n1 = key_idx + 2'd1;
      n2 = key_idx + 2'd2;
      n3 = key_idx + 2'd3;
      found = nv[n1] | nv[n2] | nv[n3];
      nxt = nv[n1] ? n1 : nv[n2] ? n2 : n3;
      nxt_data = (key_load && key_load_idx == nxt) ? key_load_data : slot[nxt];
      rot = (state == ROTATE) && tick5 && found;
      first_load = (state == EMPTY) && key_load;
      act_load = (state != EMPTY) && key_load && key_load_idx == key_idx;
   end
   // State register
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) state <= EMPTY;
      else state <= state_n;
   // Next state: EMPTY exits on first load; afterwards only rotate_en toggles READY/ROTATE
   always_comb begin
      state_n = state;
      state_n = (state == EMPTY) ? (key_load ? READY : EMPTY) : (rotate_en ? ROTATE : READY);
   end
   // Slot storage and active-key outputs
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < NUM_KEYS; i++) slot[i] <= '0;
         slot_valid <= '0;
         key_out <= '0;
         key_idx <= '0;
         key_valid <= 1'b0;
      end else begin
         if (key_load) begin
            slot[key_load_idx] <= key_load_data;
            slot_valid[key_load_idx] <= 1'b1;
         end
         key_idx <= first_load ? key_load_idx : rot ? nxt : key_idx;
         key_out <= rot ? nxt_data : (first_load || act_load) ? key_load_data : key_out;
         key_valid <= first_load | rot | act_load;
      end
`ifdef KEY_ROTATE_SCAN_EN
   logic [2:0] s500;
   logic [1:0] scan;
   // Display scanner: advance one digit per 500 Hz tick and register the matching nibble
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) begin
         s500 <= '0;
         scan <= '0;
         seg_nib <= '0;
      end else begin
         s500 <= {s500[1:0], clk_500Hz};
         if (armed && s500[1] && !s500[2]) scan <= scan + 2'd1;
         seg_nib <= key_out[{scan, 2'b00} +: 4];
      end
   assign seg_an = ~(4'b0001 << scan);
`else
   logic unused_500hz;
   assign unused_500hz = clk_500Hz;
   assign seg_an = 4'b1111;
   assign seg_nib = 4'h0;
`endif
endmodule

// File: tb/tb_rtc_key_rotator.sv
// tb_rtc_key_rotator: directed self-checking bench for rtc_key_rotator
`timescale 1ns/1ps
module tb_rtc_key_rotator;
   logic sys_clk = 0, rst_n = 1, clk_500Hz = 0, clk_5s = 0, rotate_en = 0, key_load = 0;
   logic [1:0] key_load_idx = 0;
   logic [31:0] key_load_data = 0;
   logic [31:0] key_out;
   logic [1:0] key_idx;
   logic key_valid;
   logic [3:0] seg_an, seg_nib;
   int checks = 0, errors = 0, vcnt = 0, v0;
`ifdef KEY_ROTATE_SCAN_EN
   localparam logic [3:0] AN_RST = 4'b1110;
`else
   localparam logic [3:0] AN_RST = 4'b1111;
`endif

   rtc_key_rotator #(.KEY_W(32), .NUM_KEYS(4)) dut (
      .sys_clk(sys_clk), .rst_n(rst_n), .clk_500Hz(clk_500Hz), .clk_5s(clk_5s),
      .rotate_en(rotate_en), .key_load(key_load), .key_load_idx(key_load_idx),
      .key_load_data(key_load_data), .key_out(key_out), .key_idx(key_idx),
      .key_valid(key_valid), .seg_an(seg_an), .seg_nib(seg_nib));

   always #500 sys_clk = ~sys_clk;

   // Count key_valid pulses, sampled mid-cycle
   always @(negedge sys_clk) if (key_valid) vcnt++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge sys_clk);
      #100;
   endtask

   task automatic load(input logic [1:0] i, input logic [31:0] d);
      key_load = 1; key_load_idx = i; key_load_data = d;
      cyc(1);
      key_load = 0;
   endtask

   task automatic rst(input string tag);
      rst_n = 0;
      #10;
      check({tag, "_out"}, key_out, 0);
      check({tag, "_idx"}, key_idx, 0);
      check({tag, "_valid"}, key_valid, 0);
      check({tag, "_an"}, seg_an, AN_RST);
      check({tag, "_nib"}, seg_nib, 0);
      cyc(1);
      rst_n = 1;
      cyc(1);
   endtask

   // One clk_5s period; the rise is synchronized and acted on at the third edge
   task automatic p5(input string tag, input logic [1:0] ei, input logic [31:0] ed, input logic ev);
      int s;
      s = vcnt;
      clk_5s = 1;
      cyc(3);
      check({tag, "_idx"}, key_idx, ei);
      check({tag, "_out"}, key_out, ed);
      check({tag, "_valid"}, key_valid, ev);
      cyc(17);
      clk_5s = 0;
      cyc(20);
      check({tag, "_pulses"}, vcnt - s, ev);
   endtask

   initial begin
      logic [3:0] an_t [4];
      logic [3:0] nib_t [4];
      an_t = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      nib_t = '{4'hD, 4'hC, 4'hB, 4'hA};
      cyc(2);
      clk_5s = 1; clk_500Hz = 1; rotate_en = 1;
      rst("por");
      cyc(10000);
      check("idle_pulses", vcnt, 0);
      check("idle_out", key_out, 0);
      check("idle_idx", key_idx, 0);
      clk_5s = 0; clk_500Hz = 0;
      cyc(5);

      load(2, 32'hDEADBEEF);
      check("first_out", key_out, 32'hDEADBEEF);
      check("first_idx", key_idx, 2);
      check("first_valid", key_valid, 1);
      cyc(1);
      v0 = vcnt;
      for (int i = 0; i < 3; i++) p5("single", 2, 32'hDEADBEEF, 0);
      check("single_total", vcnt - v0, 0);

      rst("mid");
      rotate_en = 0;
      load(0, 32'h11111111);
      check("s0_out", key_out, 32'h11111111);
      load(1, 32'h22222222);
      check("inactive_out", key_out, 32'h11111111);
      check("inactive_valid", key_valid, 0);
      load(3, 32'h33333333);
      rotate_en = 1;
      cyc(1);
      p5("rot1", 1, 32'h22222222, 1);
      p5("rot2", 3, 32'h33333333, 1);
      p5("rot3", 0, 32'h11111111, 1);
      p5("rot4", 1, 32'h22222222, 1);
      load(1, 32'h55555555);
      check("active_out", key_out, 32'h55555555);
      check("active_valid", key_valid, 1);

      rst("r2");
      rotate_en = 0;
      load(0, 32'hAAAAAAAA);
      rotate_en = 1;
      cyc(2);
      clk_5s = 1;
      cyc(2);
      load(1, 32'h12345678);
      check("coinc_idx", key_idx, 1);
      check("coinc_out", key_out, 32'h12345678);
      check("coinc_valid", key_valid, 1);
      cyc(20);
      clk_5s = 0;
      cyc(20);

`ifdef KEY_ROTATE_SCAN_EN
      rst("r3");
      rotate_en = 0;
      load(0, 32'h0000ABCD);
      cyc(2);
      check("scan0_an", seg_an, an_t[0]);
      check("scan0_nib", seg_nib, nib_t[0]);
      for (int k = 1; k <= 4; k++) begin
         clk_500Hz = 1;
         cyc(1000);
         clk_500Hz = 0;
         cyc(1000);
         check($sformatf("scan%0d_an", k), seg_an, an_t[k % 4]);
         check($sformatf("scan%0d_nib", k), seg_nib, nib_t[k % 4]);
      end
`else
      check("noscan_an", seg_an, 4'b1111);
      check("noscan_nib", seg_nib, 0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
